// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
//   DATA_W / REG_ADDR_W : operand and register-address widths
//   ALU_OP_*            : alu_control encodings (add, shift-left)
//   issue_entry_t       : one buffered operation {in1, in2, op, rd}
//   occ_t               : skid-buffer occupancy {EMPTY, ONE, FULL}
package alu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SHL = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0]     in1;
        logic [DATA_W-1:0]     in2;
        logic                  op;
        logic [REG_ADDR_W-1:0] rd;
    } issue_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/alu_issue_stage_operand_mux.sv
// issue_operand_mux: combinational operand selection for the issue stage.
// Builds the entry to be captured from the decoded operation:
//   in1 = rs1 value, in2 = immediate or rs2 value, op / rd passed through.
// Optional feature macro ALU_ISSUE_FWD_EN: when defined, a matching writeback
// bypass (fwd_valid, fwd_rd == rsX, rsX != 0) replaces the register-file value.
// rs2 is not forwarded when the immediate is selected.
// Ports:
//   rs1, rs2, rs1_data, rs2_data, imm, use_imm, op, rd : decoded operation
//   fwd_valid, fwd_rd, fwd_data                        : writeback bypass
//   entry                                              : assembled issue entry
module issue_operand_mux
    import alu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0]     rs1_data,
    input  logic [DATA_W-1:0]     rs2_data,
    input  logic [DATA_W-1:0]     imm,
    input  logic                  use_imm,
    input  logic                  op,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [DATA_W-1:0]     fwd_data,
    output issue_entry_t          entry
);

    logic [DATA_W-1:0] src_val [2];

`ifdef ALU_ISSUE_FWD_EN
    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [DATA_W-1:0]     src_raw  [2];
    logic                  src_en   [2];

    assign src_addr[0] = rs1;
    assign src_addr[1] = rs2;
    assign src_raw[0]  = rs1_data;
    assign src_raw[1]  = rs2_data;
    // rs2 bypass is pointless when the immediate supplies operand 2.
    assign src_en[0]   = 1'b1;
    assign src_en[1]   = !use_imm;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // Register 0 is hard-wired zero, so it never takes a bypass.
            assign src_val[gi] = (src_en[gi] && fwd_valid && (fwd_rd == src_addr[gi])
                                  && (src_addr[gi] != '0)) ? fwd_data : src_raw[gi];
        end
    endgenerate
`else
    // Bypass inputs exist on the interface but carry no meaning in this build.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs1, rs2};

    assign src_val[0] = rs1_data;
    assign src_val[1] = rs2_data;
`endif

    // No masking of in2: the ALU defines shifts of DATA_W or more.
    assign entry.in1 = src_val[0];
    assign entry.in2 = use_imm ? imm : src_val[1];
    assign entry.op  = op;
    assign entry.rd  = rd;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute stage feeding the 8-bit add/shift ALU.
// Two-entry skid buffer (main + skid) so in_ready comes straight from a flop.
// Optional feature macro ALU_ISSUE_FWD_EN enables writeback forwarding in
// the operand mux.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready, in_op, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
//   in_imm, in_use_imm, in_rd          : upstream decoded operation
//   flush                              : drop all buffered operations
//   fwd_valid, fwd_rd, fwd_data        : writeback bypass
//   out_valid/out_ready, out_in1, out_in2, out_alu_control, out_rd : to ALU
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_op,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0]     in_rs1_data,
    input  logic [DATA_W-1:0]     in_rs2_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  flush,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [DATA_W-1:0]     fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_in1,
    output logic [DATA_W-1:0]     out_in2,
    output logic                  out_alu_control,
    output logic [REG_ADDR_W-1:0] out_rd
);

    occ_t         state_reg;
    issue_entry_t main_reg;
    issue_entry_t skid_reg;
    issue_entry_t capture_next;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         take_in;
    logic         take_out;

    issue_operand_mux u_operand_mux (
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .rs1_data  (in_rs1_data),
        .rs2_data  (in_rs2_data),
        .imm       (in_imm),
        .use_imm   (in_use_imm),
        .op        (in_op),
        .rd        (in_rd),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .entry     (capture_next)
    );

    assign take_in  = in_valid && in_ready_reg;
    assign take_out = out_valid_reg && out_ready;

    // Occupancy FSM; in_ready/out_valid are updated alongside the state so
    // both leave the stage directly from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            // Any transfer-out this cycle has already been seen by the ALU;
            // any transfer-in this cycle is simply not captured.
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (take_in) begin
                        main_reg      <= capture_next;
                        state_reg     <= ONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (take_in && !take_out) begin
                        skid_reg     <= capture_next;
                        state_reg    <= FULL;
                        in_ready_reg <= 1'b0;
                    end else if (take_in && take_out) begin
                        main_reg <= capture_next;
                    end else if (take_out) begin
                        main_reg      <= '0;
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                FULL: begin
                    if (take_out) begin
                        main_reg     <= skid_reg;
                        skid_reg     <= '0;
                        state_reg    <= ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_reg;
    assign out_valid       = out_valid_reg;
    assign out_in1         = main_reg.in1;
    assign out_in2         = main_reg.in2;
    assign out_alu_control = main_reg.op;
    assign out_rd          = main_reg.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a vector table of single
// operations plus hand-written skid, flush and reset sequences.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_op;
    logic [2:0] in_rs1, in_rs2, in_rd;
    logic [7:0] in_rs1_data, in_rs2_data, in_imm;
    logic       in_use_imm;
    logic       flush;
    logic       fwd_valid;
    logic [2:0] fwd_rd;
    logic [7:0] fwd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_in1, out_in2;
    logic       out_alu_control;
    logic [2:0] out_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_use_imm      (in_use_imm),
        .in_rd           (in_rd),
        .flush           (flush),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_in1         (out_in1),
        .out_in2         (out_in2),
        .out_alu_control (out_alu_control),
        .out_rd          (out_rd)
    );

    typedef struct packed {
        logic       op;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] rs1d;
        logic [7:0] rs2d;
        logic [7:0] imm;
        logic       use_imm;
        logic [2:0] rd;
        logic       fwv;
        logic [2:0] fwrd;
        logic [7:0] fwd;
        logic [7:0] e_in1;
        logic [7:0] e_in2;
        logic [7:0] e_alu;
    } vec_t;

    vec_t vecs [8];

    // Reference ALU: add, or shift-left where shifts of 8+ give zero.
    function automatic logic [7:0] alu_ref(input logic op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (op) r = (b >= 8) ? 8'h00 : (a << b);
        else    r = a + b;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic op, input logic [7:0] rs1d, input logic [7:0] rs2d,
                            input logic [2:0] rd);
        in_valid    = 1'b1;
        in_op       = op;
        in_rs1      = 3'd1;
        in_rs2      = 3'd2;
        in_rs1_data = rs1d;
        in_rs2_data = rs2d;
        in_imm      = 8'h00;
        in_use_imm  = 1'b0;
        in_rd       = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_use_imm = 1'b0; flush = 1'b0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0; out_ready = 1'b0;

        //             op    rs1   rs2   rs1d   rs2d   imm    ui    rd    fwv   fwrd  fwd    e_in1  e_in2  e_alu
        vecs[0] = '{1'b0, 3'd1, 3'd2, 8'h12, 8'h34, 8'h00, 1'b0, 3'd1, 1'b0, 3'd0, 8'h00, 8'h12, 8'h34, 8'h46};
        vecs[1] = '{1'b1, 3'd1, 3'd2, 8'h03, 8'h55, 8'h02, 1'b1, 3'd3, 1'b0, 3'd0, 8'h00, 8'h03, 8'h02, 8'h0C};
        vecs[2] = '{1'b0, 3'd4, 3'd5, 8'hF0, 8'h00, 8'h20, 1'b1, 3'd7, 1'b0, 3'd0, 8'h00, 8'hF0, 8'h20, 8'h10};
        vecs[3] = '{1'b1, 3'd1, 3'd2, 8'h01, 8'h09, 8'h00, 1'b0, 3'd2, 1'b0, 3'd0, 8'h00, 8'h01, 8'h09, 8'h00};
        vecs[4] = '{1'b0, 3'd2, 3'd3, 8'h00, 8'h01, 8'h00, 1'b0, 3'd4, 1'b1, 3'd2, 8'hAA,
                    FWD_ON ? 8'hAA : 8'h00, 8'h01, FWD_ON ? 8'hAB : 8'h01};
        vecs[5] = '{1'b0, 3'd0, 3'd3, 8'h00, 8'h01, 8'h00, 1'b0, 3'd4, 1'b1, 3'd0, 8'hAA, 8'h00, 8'h01, 8'h01};
        vecs[6] = '{1'b0, 3'd3, 3'd2, 8'h07, 8'h11, 8'h05, 1'b1, 3'd5, 1'b1, 3'd2, 8'hAA, 8'h07, 8'h05, 8'h0C};
        vecs[7] = '{1'b0, 3'd3, 3'd2, 8'h07, 8'h11, 8'h05, 1'b0, 3'd6, 1'b1, 3'd2, 8'hAA,
                    8'h07, FWD_ON ? 8'hAA : 8'h11, FWD_ON ? 8'hB1 : 8'h18};

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_in_ready", {31'b0, in_ready}, 1);
        check("reset_outputs", {13'b0, out_in1, out_in2, out_alu_control, out_rd}, 0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Single operations through an otherwise empty stage.
        for (int i = 0; i < 8; i++) begin
            in_valid    = 1'b1;
            in_op       = vecs[i].op;
            in_rs1      = vecs[i].rs1;
            in_rs2      = vecs[i].rs2;
            in_rs1_data = vecs[i].rs1d;
            in_rs2_data = vecs[i].rs2d;
            in_imm      = vecs[i].imm;
            in_use_imm  = vecs[i].use_imm;
            in_rd       = vecs[i].rd;
            fwd_valid   = vecs[i].fwv;
            fwd_rd      = vecs[i].fwrd;
            fwd_data    = vecs[i].fwd;
            tick();
            // Register-file data only needs to hold in the capture cycle.
            in_valid = 1'b0; in_rs1_data = 8'hEE; in_rs2_data = 8'hEE; in_imm = 8'hEE;
            fwd_valid = 1'b0;
            $display("vec %0d: in1=0x%02h in2=0x%02h ctl=%0d rd=%0d alu=0x%02h",
                     i, out_in1, out_in2, out_alu_control, out_rd, alu_ref(out_alu_control, out_in1, out_in2));
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 1);
            check($sformatf("vec%0d_in1", i), {24'b0, out_in1}, {24'b0, vecs[i].e_in1});
            check($sformatf("vec%0d_in2", i), {24'b0, out_in2}, {24'b0, vecs[i].e_in2});
            check($sformatf("vec%0d_ctl", i), {31'b0, out_alu_control}, {31'b0, vecs[i].op});
            check($sformatf("vec%0d_rd", i), {29'b0, out_rd}, {29'b0, vecs[i].rd});
            check($sformatf("vec%0d_alu", i), {24'b0, alu_ref(out_alu_control, out_in1, out_in2)},
                  {24'b0, vecs[i].e_alu});
            tick();
            check($sformatf("vec%0d_drain", i), {31'b0, out_valid}, 0);
        end

        // Back-pressure: A and B fill the buffer, C is held off.
        out_ready = 1'b0;
        drive_op(1'b0, 8'hA1, 8'h01, 3'd1);
        tick();
        check("skid_a_ready", {31'b0, in_ready}, 1);
        check("skid_a_in1", {24'b0, out_in1}, 32'hA1);
        drive_op(1'b0, 8'hB2, 8'h02, 3'd2);
        tick();
        check("skid_full_ready", {31'b0, in_ready}, 0);
        drive_op(1'b0, 8'hC3, 8'h03, 3'd3);
        tick();
        check("skid_hold_ready", {31'b0, in_ready}, 0);
        check("skid_hold_in1", {24'b0, out_in1}, 32'hA1);
        check("skid_hold_rd", {29'b0, out_rd}, 1);
        out_ready = 1'b1;
        tick();
        $display("skid: after A out in1=0x%02h rd=%0d", out_in1, out_rd);
        check("skid_b_in1", {24'b0, out_in1}, 32'hB2);
        check("skid_b_ready", {31'b0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        $display("skid: after B out in1=0x%02h rd=%0d", out_in1, out_rd);
        check("skid_c_in1", {24'b0, out_in1}, 32'hC3);
        check("skid_c_valid", {31'b0, out_valid}, 1);
        tick();
        check("skid_c_drain", {31'b0, out_valid}, 0);

        // Flush from FULL, with a competing transfer-in that must be dropped.
        out_ready = 1'b0;
        drive_op(1'b0, 8'h11, 8'h00, 3'd1);
        tick();
        drive_op(1'b0, 8'h22, 8'h00, 3'd2);
        tick();
        check("flush_pre_full", {31'b0, in_ready}, 0);
        flush = 1'b1;
        drive_op(1'b0, 8'h33, 8'h00, 3'd3);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        $display("flush: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("flush_valid", {31'b0, out_valid}, 0);
        check("flush_ready", {31'b0, in_ready}, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("flush_quiet%0d", k), {31'b0, out_valid}, 0);
        end

        // Flush in ONE with in_valid also high: the new op is not captured.
        drive_op(1'b0, 8'h44, 8'h00, 3'd4);
        tick();
        flush = 1'b1;
        drive_op(1'b0, 8'h55, 8'h00, 3'd5);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_one_valid", {31'b0, out_valid}, 0);
        tick();
        check("flush_one_quiet", {31'b0, out_valid}, 0);

        // Reset while FULL.
        out_ready = 1'b0;
        drive_op(1'b1, 8'h66, 8'h01, 3'd6);
        tick();
        drive_op(1'b1, 8'h77, 8'h02, 3'd7);
        tick();
        in_valid = 1'b0;
        check("rst_pre_full", {31'b0, in_ready}, 0);
        reset = 1'b1;
        tick();
        $display("reset in FULL: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("rst_full_valid", {31'b0, out_valid}, 0);
        check("rst_full_ready", {31'b0, in_ready}, 1);
        check("rst_full_outputs", {13'b0, out_in1, out_in2, out_alu_control, out_rd}, 0);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        check("rst_after_valid", {31'b0, out_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
